vga_fb_writer: RTL and testbench

//  Write-side engine for the 1-bit falling-key frame buffer: drives port A (wea/addra/dina) of the frame buffer RAM

---
 rtl/vga_fb_writer.sv | 139 +++++++++++++
 tb/tb_vga_fb_writer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_writer.sv
// Write-side engine for the 1-bit frame buffer: takes FILL/CLEAR_ALL commands
// and streams one pixel word per clock into RAM port A, optionally only during vblank.
module vga_fb_writer #(
  parameter int SYNC_VBLANK = 0
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_lane,
  input  logic [8:0]  cmd_row,
  input  logic [8:0]  cmd_len,
  input  logic        cmd_value,
  input  logic        vblank,
  output logic [11:0] vga_ram_addr,
  output logic        vga_ram_din,
  output logic        vga_ram_we,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a command transfers on the clk50 edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only while idle, and the
  // command fields are sampled on that edge alone.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] OP_FILL  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;

  state_t      state_q;
  logic        op_clear_q;
  logic [11:0] addr_cnt_q;
  logic [12:0] rem_q;
  logic        we_q;
  logic [11:0] addr_q;
  logic        din_q;
  logic        busy_q;
  logic        done_q;
  logic        ready_q;

  logic        accept_d;
  logic        start_write_d;
  logic        hold_d;
  logic [11:0] addr_step_d;
  logic [11:0] addr_next_d;
  logic [12:0] rem_next_d;

  always_comb begin
    accept_d      = 1'b0;
    start_write_d = 1'b0;
    hold_d        = 1'b0;
    addr_step_d   = 12'd8;
    accept_d      = cmd_valid && ready_q && (state_q == IDLE);
    start_write_d = (cmd_op == OP_CLEAR) || ((cmd_op == OP_FILL) && (cmd_len != 9'd0));
    hold_d        = (SYNC_VBLANK != 0) && !vblank;
    // FILL steps one row (+8) so the lane bits never change and the row wraps mod 512.
    if (op_clear_q) addr_step_d = 12'd1;
  end

  assign addr_next_d = addr_cnt_q + addr_step_d;
  assign rem_next_d  = rem_q - 13'd1;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_clear_q <= 1'b0;
      addr_cnt_q <= 12'd0;
      rem_q      <= 13'd0;
      we_q       <= 1'b0;
      addr_q     <= 12'd0;
      din_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            din_q      <= cmd_value;
            op_clear_q <= (cmd_op == OP_CLEAR);
            if (cmd_op == OP_CLEAR) begin
              addr_cnt_q <= 12'd0;
              rem_q      <= 13'd4096;
            end else begin
              addr_cnt_q <= {cmd_row, cmd_lane};
              rem_q      <= {4'd0, cmd_len};
            end
            if (!start_write_d) state_q <= DONE;
            else if (hold_d)    state_q <= WAIT_VB;
            else                state_q <= WRITE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT_VB: begin
          if (vblank) state_q <= WRITE;
        end
        WRITE: begin
          // Leaving vblank drops this word; the counters stay put so it is retried.
          if (hold_d) begin
            state_q <= WAIT_VB;
          end else begin
            we_q       <= 1'b1;
            addr_q     <= addr_cnt_q;
            addr_cnt_q <= addr_next_d;
            rem_q      <= rem_next_d;
            if (rem_q == 13'd1) state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = ready_q;
  assign vga_ram_addr = addr_q;
  assign vga_ram_din  = din_q;
  assign vga_ram_we   = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer: u0 ignores vblank, u1 confines writes to vblank.
module tb_vga_fb_writer;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        valid0, valid1;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_lane;
  logic [8:0]  cmd_row, cmd_len;
  logic        cmd_value;
  logic        vblank;

  logic        ready0, din0, we0, busy0, done0;
  logic [11:0] addr0;
  logic [1:0]  st0;
  logic        ready1, din1, we1, busy1, done1;
  logic [11:0] addr1;
  logic [1:0]  st1;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];

  always #10 clk50 = ~clk50;

  vga_fb_writer #(.SYNC_VBLANK(0)) u0 (
    .clk50(clk50), .reset(reset), .cmd_valid(valid0), .cmd_ready(ready0),
    .cmd_op(cmd_op), .cmd_lane(cmd_lane), .cmd_row(cmd_row), .cmd_len(cmd_len),
    .cmd_value(cmd_value), .vblank(vblank), .vga_ram_addr(addr0), .vga_ram_din(din0),
    .vga_ram_we(we0), .busy(busy0), .done(done0), .dbg_state_o(st0)
  );

  vga_fb_writer #(.SYNC_VBLANK(1)) u1 (
    .clk50(clk50), .reset(reset), .cmd_valid(valid1), .cmd_ready(ready1),
    .cmd_op(cmd_op), .cmd_lane(cmd_lane), .cmd_row(cmd_row), .cmd_len(cmd_len),
    .cmd_value(cmd_value), .vblank(vblank), .vga_ram_addr(addr1), .vga_ram_din(din1),
    .vga_ram_we(we1), .busy(busy1), .done(done1), .dbg_state_o(st1)
  );

  task automatic tick;
    @(posedge clk50);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [2:0] lane,
                         input logic [8:0] row, input logic [8:0] len, input logic value);
    cmd_op    = op;
    cmd_lane  = lane;
    cmd_row   = row;
    cmd_len   = len;
    cmd_value = value;
  endtask

  // Issue the current command to u0 and check the exact cycle sequence against exp_q.
  task automatic run_u0(input string name, input logic value);
    int n, bad, bad_idx;
    logic [11:0] e, bad_addr, bad_exp;
    logic bad_we, bad_din;
    bad = 0; bad_idx = 0; bad_addr = '0; bad_exp = '0; bad_we = 1'b0; bad_din = 1'b0;
    vectors++;
    if (ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before: got cmd_ready=%b want 1", name, ready0);
    end
    valid0 = 1'b1;
    tick;
    valid0 = 1'b0;
    vectors++;
    if (busy0 !== 1'b1 || we0 !== 1'b0 || ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s accept: got busy=%b we=%b ready=%b want 1 0 0", name, busy0, we0, ready0);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick;
      e = exp_q.pop_front();
      if (we0 !== 1'b1 || addr0 !== e || din0 !== value) begin
        if (bad == 0) begin
          bad_idx = i; bad_addr = addr0; bad_exp = e; bad_we = we0; bad_din = din0;
        end
        bad++;
      end
    end
    if (n > 0) begin
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL %s writes: %0d bad cycles, first #%0d got we=%b addr=%h din=%b want we=1 addr=%h din=%b",
                 name, bad, bad_idx, bad_we, bad_addr, bad_din, bad_exp, value);
      end
    end
    tick;
    vectors++;
    if (we0 !== 1'b0 || done0 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done: got we=%b done=%b want 0 1", name, we0, done0);
    end
    tick;
    vectors++;
    if (done0 !== 1'b0 || ready0 !== 1'b1 || busy0 !== 1'b0 || we0 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: got done=%b ready=%b busy=%b we=%b want 0 1 0 0",
               name, done0, ready0, busy0, we0);
    end
  endtask

  task automatic test_reset;
    tick;
    tick;
    vectors++;
    if ({we0, addr0, busy0, done0, ready0, st0} !== 18'd0 ||
        {we1, addr1, busy1, done1, ready1, st1} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got u0 we=%b addr=%h busy=%b done=%b ready=%b u1 ready=%b want all 0",
               we0, addr0, busy0, done0, ready0, ready1);
    end
    reset = 1'b0;
    tick;
    vectors++;
    if (ready0 !== 1'b1 || ready1 !== 1'b1 || we0 !== 1'b0 || addr0 !== 12'h000 ||
        busy0 !== 1'b0 || done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got ready0=%b ready1=%b we=%b addr=%h busy=%b done=%b want 1 1 0 000 0 0",
               ready0, ready1, we0, addr0, busy0, done0);
    end
  endtask

  task automatic test_fill;
    set_cmd(2'b00, 3'd3, 9'd10, 9'd4, 1'b1);
    exp_q.delete();
    exp_q.push_back(12'h053); exp_q.push_back(12'h05B);
    exp_q.push_back(12'h063); exp_q.push_back(12'h06B);
    run_u0("fill_basic", 1'b1);
  endtask

  task automatic test_row_wrap;
    set_cmd(2'b00, 3'd6, 9'd510, 9'd3, 1'b1);
    exp_q.delete();
    exp_q.push_back(12'hFF6); exp_q.push_back(12'hFFE); exp_q.push_back(12'h006);
    run_u0("fill_wrap", 1'b1);
  endtask

  task automatic test_back_to_back;
    set_cmd(2'b00, 3'd0, 9'd0, 9'd2, 1'b0);
    exp_q.delete();
    exp_q.push_back(12'h000); exp_q.push_back(12'h008);
    run_u0("b2b_first", 1'b0);
    set_cmd(2'b00, 3'd7, 9'd511, 9'd1, 1'b1);
    exp_q.push_back(12'hFFF);
    run_u0("b2b_second", 1'b1);
  endtask

  task automatic test_clear_all;
    set_cmd(2'b01, 3'd5, 9'd77, 9'd9, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 4096; i++) exp_q.push_back(12'(i));
    run_u0("clear_all", 1'b0);
  endtask

  task automatic test_len_zero;
    set_cmd(2'b00, 3'd2, 9'd3, 9'd0, 1'b1);
    exp_q.delete();
    run_u0("fill_len0", 1'b1);
    set_cmd(2'b10, 3'd1, 9'd1, 9'd5, 1'b1);
    run_u0("nop", 1'b1);
  endtask

  task automatic test_sync_vblank;
    int writes, dones, bad;
    logic [11:0] e;
    writes = 0; dones = 0; bad = 0;
    set_cmd(2'b00, 3'd2, 9'd0, 9'd8, 1'b1);
    vblank = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(12'(i * 8 + 2));
    vectors++;
    if (ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL vb_ready_before: got cmd_ready=%b want 1", ready1);
    end
    valid1 = 1'b1;
    tick;
    valid1 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      vblank = ((c >= 2) && (c < 6)) || (c >= 10);
      if (c >= 6 && c < 10) begin
        valid1 = 1'b1;
        set_cmd(2'b01, 3'd7, 9'd100, 9'd50, 1'b0);
      end else begin
        valid1 = 1'b0;
      end
      tick;
      if (c == 1) begin
        vectors++;
        if (busy1 !== 1'b1 || we1 !== 1'b0) begin
          miscompares++;
          $display("FAIL vb_wait: got busy=%b we=%b want 1 0", busy1, we1);
        end
      end
      if (we1 === 1'b1) begin
        writes++;
        if (!vblank) bad++;
        if (exp_q.size() == 0) bad++;
        else begin
          e = exp_q.pop_front();
          if (addr1 !== e || din1 !== 1'b1) bad++;
        end
      end
      if (done1 === 1'b1) dones++;
    end
    vblank = 1'b0;
    vectors++;
    if (writes != 8 || bad != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL vb_writes: got %0d writes %0d bad %0d unwritten want 8 0 0", writes, bad, exp_q.size());
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL vb_done: got %0d done pulses want 1", dones);
    end
    vectors++;
    if (busy1 !== 1'b0 || ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL vb_idle: got busy=%b ready=%b want 0 1", busy1, ready1);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    set_cmd(2'b00, 3'd1, 9'd20, 9'd10, 1'b1);
    valid0 = 1'b1;
    tick;
    valid0 = 1'b0;
    tick;
    tick;
    vectors++;
    if (we0 !== 1'b1 || addr0 !== 12'h0A9) begin
      miscompares++;
      $display("FAIL mid_pre_reset: got we=%b addr=%h want 1 0a9", we0, addr0);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (we0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || addr0 !== 12'h000 || st0 !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_async_reset: got we=%b busy=%b done=%b addr=%h state=%0d want 0 0 0 000 0",
               we0, busy0, done0, addr0, st0);
    end
    tick;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done0 === 1'b1 || we0 === 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mid_discard: got %0d cycles with we or done after reset want 0", bad);
    end
    set_cmd(2'b00, 3'd4, 9'd300, 9'd3, 1'b1);
    exp_q.delete();
    exp_q.push_back(12'h964); exp_q.push_back(12'h96C); exp_q.push_back(12'h974);
    run_u0("post_reset", 1'b1);
  endtask

  initial begin
    reset  = 1'b1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    vblank = 1'b0;
    set_cmd(2'b11, 3'd0, 9'd0, 9'd0, 1'b0);
    test_reset();
    test_fill();
    test_row_wrap();
    test_back_to_back();
    test_clear_all();
    test_len_zero();
    test_sync_vblank();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
